// File: rtl/jtag_gpio_ctrl.sv
// DR-side controller behind the virtual JTAG TAP: capture/shift/update for BYPASS, IDCODE,
// CONFIG, DATA and STATUS registers, with length-checked commits to the GPIO output/enable state.
module jtag_gpio_ctrl #(
    parameter int                  IR_BITS   = 4,
    parameter int                  NR_GPIOS  = 8,
    parameter logic [31:0]         ID_CODE   = 32'h1234_5678,
    parameter logic [NR_GPIOS-1:0] OUT_RESET = '0
) (
    input  logic                tck,
    input  logic                reset_,
    input  logic [IR_BITS-1:0]  ir,
    input  logic                tdi,
    output logic                tdo,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic [NR_GPIOS-1:0] gpio_in,
    output logic [NR_GPIOS-1:0] gpio_out,
    output logic [NR_GPIOS-1:0] gpio_oe
);
    localparam int W = 32;
    localparam logic [IR_BITS-1:0] IR_IDCODE = IR_BITS'(1);
    localparam logic [IR_BITS-1:0] IR_CONFIG = IR_BITS'(2);
    localparam logic [IR_BITS-1:0] IR_DATA   = IR_BITS'(3);
    localparam logic [IR_BITS-1:0] IR_STATUS = IR_BITS'(4);

    logic [W-1:0]        sr, sr_cap, sr_shf, sr_hi;
    logic [5:0]          cnt, len;
    logic [NR_GPIOS-1:0] sync_meta, gpio_sync;
    logic                len_err;
    logic [3:0]          upd_cnt;
    logic                is_cfg, is_data, is_stat, len_ok;

    assign is_cfg  = (ir == IR_CONFIG);
    assign is_data = (ir == IR_DATA);
    assign is_stat = (ir == IR_STATUS);
    assign len_ok  = (cnt == len);
    assign tdo     = sr[0];
    assign sr_hi   = {1'b0, sr[W-1:1]};

    always_comb begin
        len    = 6'd1;
        sr_cap = '0;
        case (ir)
            IR_IDCODE: begin len = 6'd32; sr_cap = ID_CODE; end
            IR_CONFIG: begin len = 6'(NR_GPIOS); sr_cap[NR_GPIOS-1:0] = gpio_oe; end
            IR_DATA:   begin len = 6'(NR_GPIOS); sr_cap[NR_GPIOS-1:0] = gpio_sync; end
            IR_STATUS: begin len = 6'd8; sr_cap[7:0] = {len_err, 3'b000, upd_cnt}; end
            default:   begin len = 6'd1; sr_cap = '0; end
        endcase
    end

    // Only the low L bits form the active chain; tdi enters at bit L-1, upper bits hold.
    always_comb begin
        sr_shf = sr;
        for (int i = 0; i < W; i++) begin
            if (i == int'(len) - 1)
                sr_shf[i] = tdi;
            else if (i < int'(len) - 1)
                sr_shf[i] = sr_hi[i];
        end
    end

    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            sync_meta <= '0;
            gpio_sync <= '0;
        end else begin
            sync_meta <= gpio_in;
            gpio_sync <= sync_meta;
        end
    end

    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            sr       <= '0;
            cnt      <= '0;
            len_err  <= 1'b0;
            upd_cnt  <= '0;
            gpio_oe  <= '0;
            gpio_out <= OUT_RESET;
        end else if (capture_dr) begin
            sr  <= sr_cap;
            cnt <= '0;
        end else if (shift_dr) begin
            sr <= sr_shf;
            if (cnt != len + 6'd1)
                cnt <= cnt + 6'd1;
        end else if (update_dr) begin
            // A scan of the wrong length never touches GPIO state; it only flags the error.
            if (is_cfg || is_data) begin
                if (len_ok) begin
                    if (is_cfg)
                        gpio_oe <= sr[NR_GPIOS-1:0];
                    else
                        gpio_out <= sr[NR_GPIOS-1:0];
                    upd_cnt <= upd_cnt + 4'd1;
                end else begin
                    len_err <= 1'b1;
                end
            end else if (is_stat && len_ok && sr[7]) begin
                len_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jtag_gpio_ctrl.sv
// Table-driven bench for jtag_gpio_ctrl: expected tdo streams are queued per scan and popped per shift.
module tb_jtag_gpio_ctrl;
    logic       tck = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] ir = 4'h0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] gpio_out, gpio_oe;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  ir;
        logic [31:0] din;
        int          n;
        bit          upd;
        logic [7:0]  gin;
        logic [31:0] cap;
        logic [7:0]  oe;
        logic [7:0]  out;
        string       name;
    } vec_t;

    vec_t tbl[$];
    bit   exp_q[$];

    jtag_gpio_ctrl #(.IR_BITS(4), .NR_GPIOS(8), .ID_CODE(32'h1234_5678), .OUT_RESET(8'h00)) dut (
        .tck(tck), .reset_(reset_), .ir(ir), .tdi(tdi), .tdo(tdo),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe)
    );

    always #5 tck = ~tck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int dr_len(input logic [3:0] code);
        case (code)
            4'h1:    return 32;
            4'h2:    return 8;
            4'h3:    return 8;
            4'h4:    return 8;
            default: return 1;
        endcase
    endfunction

    function automatic vec_t mk(input logic [3:0] i, input logic [31:0] d, input int n, input bit u,
                                input logic [7:0] g, input logic [31:0] c, input logic [7:0] oe,
                                input logic [7:0] o, input string nm);
        vec_t v;
        v.ir = i; v.din = d; v.n = n; v.upd = u; v.gin = g;
        v.cap = c; v.oe = oe; v.out = o; v.name = nm;
        return v;
    endfunction

    // Capture, n shifts (tdo sampled on the negedge before each shift edge), optional update.
    task automatic scan(input vec_t v);
        int L;
        bit e;
        L = dr_len(v.ir);
        for (int k = 0; k < v.n; k++)
            exp_q.push_back(k < L ? v.cap[k] : v.din[k - L]);
        gpio_in = v.gin;
        repeat (3) @(negedge tck);
        ir = v.ir;
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            e = exp_q.pop_front();
            check($sformatf("tdo_%s[%0d]", v.name, k), 32'(tdo), 32'(e));
            shift_dr = 1'b1;
            tdi = v.din[k];
            @(negedge tck);
        end
        shift_dr = 1'b0;
        tdi = 1'b0;
        if (v.upd) begin
            update_dr = 1'b1;
            @(negedge tck);
            update_dr = 1'b0;
        end
        check({"oe_", v.name}, 32'(gpio_oe), 32'(v.oe));
        check({"out_", v.name}, 32'(gpio_out), 32'(v.out));
    endtask

    initial begin
        tbl.push_back(mk(4'h1, 32'h0,   32, 1'b0, 8'h00, 32'h1234_5678, 8'h00, 8'h00, "idcode"));
        tbl.push_back(mk(4'h2, 32'hA5,   8, 1'b1, 8'h00, 32'h00,        8'hA5, 8'h00, "config_wr"));
        tbl.push_back(mk(4'h4, 32'h00,   8, 1'b1, 8'h00, 32'h01,        8'hA5, 8'h00, "status_rd1"));
        tbl.push_back(mk(4'h3, 32'h3C,   7, 1'b1, 8'h00, 32'h00,        8'hA5, 8'h00, "data_short"));
        tbl.push_back(mk(4'h4, 32'h80,   8, 1'b1, 8'h00, 32'h81,        8'hA5, 8'h00, "status_clr"));
        tbl.push_back(mk(4'h4, 32'h00,   8, 1'b0, 8'h00, 32'h01,        8'hA5, 8'h00, "status_rd2"));
        tbl.push_back(mk(4'h3, 32'h96,   8, 1'b1, 8'h5A, 32'h5A,        8'hA5, 8'h96, "data_wr"));
        tbl.push_back(mk(4'hF, 32'h5,    3, 1'b1, 8'h5A, 32'h0,         8'hA5, 8'h96, "bypass"));
        tbl.push_back(mk(4'h4, 32'h00,   8, 1'b0, 8'h5A, 32'h02,        8'hA5, 8'h96, "status_rd3"));
        tbl.push_back(mk(4'h2, 32'h1FF,  9, 1'b1, 8'h5A, 32'hA5,        8'hA5, 8'h96, "config_long"));
        tbl.push_back(mk(4'h4, 32'h80,   8, 1'b1, 8'h5A, 32'h82,        8'hA5, 8'h96, "status_clr2"));
        tbl.push_back(mk(4'h1, 32'h0,    5, 1'b1, 8'h5A, 32'h1234_5678, 8'hA5, 8'h96, "idcode_upd"));
        tbl.push_back(mk(4'h4, 32'h00,   8, 1'b0, 8'h5A, 32'h02,        8'hA5, 8'h96, "status_rd4"));

        #1;
        check("rst_tdo", 32'(tdo), 32'h0);
        check("rst_oe", 32'(gpio_oe), 32'h0);
        check("rst_out", 32'(gpio_out), 32'h0);
        @(negedge tck);
        @(negedge tck);
        reset_ = 1'b1;

        foreach (tbl[i]) scan(tbl[i]);

        // Reset in the middle of a DATA scan, then an update with no fresh capture.
        @(negedge tck);
        ir = 4'h3;
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tdo_midrst[%0d]", k), 32'(tdo), 32'(k[0]));
            shift_dr = 1'b1;
            tdi = 1'b1;
            @(negedge tck);
        end
        shift_dr = 1'b0;
        reset_ = 1'b0;
        #1;
        check("midrst_tdo", 32'(tdo), 32'h0);
        check("midrst_oe", 32'(gpio_oe), 32'h0);
        check("midrst_out", 32'(gpio_out), 32'h0);
        @(negedge tck);
        reset_ = 1'b1;
        update_dr = 1'b1;
        @(negedge tck);
        update_dr = 1'b0;
        check("post_upd_oe", 32'(gpio_oe), 32'h0);
        check("post_upd_out", 32'(gpio_out), 32'h0);
        scan(mk(4'h4, 32'h00, 8, 1'b0, 8'h5A, 32'h80, 8'h00, 8'h00, "status_after_rst"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end
endmodule
